// File: rtl/iir_cfg_ctrl.sv
// iir_cfg_ctrl: shadow/active coefficient sets for the IIR core, atomic commit,
// post-commit flush and sample gating. Optional readback port under IIR_CFG_READBACK_EN.
module iir_cfg_ctrl #(
  parameter int W            = 16,
  parameter int MAX_ORDER    = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_addr,
  input  logic [W-1:0]      cfg_data,
  input  logic              cfg_commit,
  input  logic [W-1:0]      x_in,
  input  logic              x_valid,
  output logic [W-1:0]      x_out,
  output logic              x_stb,
  output logic [15*W-1:0]   coef_out,
  output logic [3:0]        order_out,
  output logic              flt_rst,
  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       drop_cnt
`ifdef IIR_CFG_READBACK_EN
  ,
  input  logic [3:0]        rd_addr,
  output logic [W-1:0]      rd_data
`endif
);

  // state  | meaning
  // IDLE   | nothing committed yet, filter held in reset
  // COMMIT | copying shadow set into the active set (first flush cycle)
  // FLUSH  | filter held in reset for the remaining flush cycles
  // RUN    | active set valid, samples pass to the core
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [3:0] MAX_ORD4 = 4'(MAX_ORDER);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   flush_cnt;
  logic [15*W-1:0]    shadow_coef;
  logic [3:0]         shadow_order;
  logic               order_legal;
  logic               commit_ok;
  logic               commit_bad;

  assign order_legal = (shadow_order != 4'd0) && (shadow_order <= MAX_ORD4);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    busy       = 1'b0;
    flt_rst    = 1'b0;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    case (state)
      ST_IDLE, ST_RUN: begin
        cfg_ready = 1'b1;
        flt_rst   = (state == ST_RUN);
        if (cfg_commit) begin
          if (order_legal) begin
            state_nxt = ST_COMMIT;
            commit_ok = 1'b1;
          end else begin
            commit_bad = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        busy      = 1'b1;
        state_nxt = (flush_cnt == '0) ? ST_RUN : ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (flush_cnt <= CNT_W'(1)) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_coef  <= '0;
      shadow_order <= '0;
      coef_out     <= '0;
      order_out    <= '0;
      flush_cnt    <= '0;
      cfg_err      <= 1'b0;
      x_out        <= '0;
      x_stb        <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        if (cfg_addr == 4'd15) shadow_order <= cfg_data[3:0];
        else                   shadow_coef[cfg_addr*W +: W] <= cfg_data;
      end

      if (commit_ok)
        flush_cnt <= FLUSH_INIT;
      else if (state == ST_FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - CNT_W'(1);

      // Shadow cannot change during COMMIT, so this copy is atomic.
      if (state == ST_COMMIT) begin
        coef_out  <= shadow_coef;
        order_out <= shadow_order;
      end

      if (commit_ok)       cfg_err <= 1'b0;
      else if (commit_bad) cfg_err <= 1'b1;

      x_stb <= 1'b0;
      if (x_valid) begin
        if (state == ST_RUN) begin
          x_out <= x_in;
          x_stb <= 1'b1;
        end else if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

`ifdef IIR_CFG_READBACK_EN
  always_ff @(posedge clk) begin
    if (!reset)               rd_data <= '0;
    else if (rd_addr == 4'd15) rd_data <= {{(W-4){1'b0}}, shadow_order};
    else                      rd_data <= shadow_coef[rd_addr*W +: W];
  end
`endif

endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// Self-checking bench for iir_cfg_ctrl: randomized writes/samples against a
// behavioural model of the shadow/active sets, commit timing and drop counting.
module tb_iir_cfg_ctrl;
  localparam int W = 16;
  localparam int FLUSH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_addr = '0;
  logic [W-1:0]      cfg_data = '0;
  logic              cfg_commit = 1'b0;
  logic [W-1:0]      x_in = '0;
  logic              x_valid = 1'b0;
  logic [W-1:0]      x_out;
  logic              x_stb;
  logic [15*W-1:0]   coef_out;
  logic [3:0]        order_out;
  logic              flt_rst;
  logic              busy;
  logic              cfg_err;
  logic [15:0]       drop_cnt;
`ifdef IIR_CFG_READBACK_EN
  logic [3:0]        rd_addr = '0;
  logic [W-1:0]      rd_data;
`endif

  iir_cfg_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .x_in(x_in), .x_valid(x_valid), .x_out(x_out), .x_stb(x_stb),
    .coef_out(coef_out), .order_out(order_out), .flt_rst(flt_rst),
    .busy(busy), .cfg_err(cfg_err), .drop_cnt(drop_cnt)
`ifdef IIR_CFG_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  logic [15:0] m_shadow [16];
  logic [15:0] m_active [15];
  logic [3:0]  m_order;
  logic        m_err;
  int          m_drop;
  logic [15:0] m_xout;

  function automatic logic [239:0] exp_coef();
    logic [239:0] v;
    v = '0;
    for (int i = 0; i < 15; i++) v[i*16 +: 16] = m_active[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_shadow[i] = '0;
    for (int i = 0; i < 15; i++) m_active[i] = '0;
    m_order = '0; m_err = 1'b0; m_drop = 0; m_xout = '0;
  endtask

  // Commit rule: legal iff 1 <= order <= 8; a legal commit takes the whole shadow set.
  task automatic model_commit();
    int ord;
    ord = int'(m_shadow[15][3:0]);
    if (ord >= 1 && ord <= 8) begin
      for (int i = 0; i < 15; i++) m_active[i] = m_shadow[i];
      m_order = m_shadow[15][3:0];
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    int n;
    n = 0;
    cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests++; failed++;
      $display("FAIL write_timeout: cfg_ready stuck at %b, required 1", cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    m_shadow[a] = (a == 4'd15) ? {12'd0, d[3:0]} : d;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    model_commit();
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      tests++; failed++;
      $display("FAIL busy_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    tests++;
    if ({coef_out, order_out, x_out, x_stb, cfg_err, drop_cnt, flt_rst} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: coef=%h order=%h x_out=%h stb=%b err=%b drop=%h flt_rst=%b, required all 0",
               coef_out, order_out, x_out, x_stb, cfg_err, drop_cnt, flt_rst);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || flt_rst !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: ready=%b busy=%b flt_rst=%b, required 1 0 0", cfg_ready, busy, flt_rst);
    end
  endtask

  task automatic test_commit_basic();
    for (int a = 0; a < 15; a++) cfg_write(4'(a), 16'($urandom));
    cfg_write(4'd0, 16'h0005);
    cfg_write(4'd1, 16'h0008);
    cfg_write(4'd9, 16'hF8E2);
    cfg_write(4'd15, 16'h0002);
    pulse_commit();
    for (int i = 0; i < FLUSH; i++) begin
      tests++;
      if (busy !== 1'b1 || flt_rst !== 1'b0 || cfg_ready !== 1'b0) begin
        failed++;
        $display("FAIL commit_busy[%0d]: busy=%b flt_rst=%b ready=%b, required 1 0 0", i, busy, flt_rst, cfg_ready);
      end
      @(negedge clk);
    end
    tests++;
    if (busy !== 1'b0 || flt_rst !== 1'b1 || cfg_ready !== 1'b1) begin
      failed++;
      $display("FAIL commit_run: busy=%b flt_rst=%b ready=%b, required 0 1 1", busy, flt_rst, cfg_ready);
    end
    tests++;
    if (coef_out !== exp_coef() || coef_out[15:0] !== 16'h0005 || coef_out[31:16] !== 16'h0008 ||
        coef_out[159:144] !== 16'hF8E2) begin
      failed++;
      $display("FAIL commit_coef: got %h, required %h", coef_out, exp_coef());
    end
    tests++;
    if (order_out !== 4'd2 || cfg_err !== 1'b0) begin
      failed++;
      $display("FAIL commit_order: order=%h err=%b, required 2 0", order_out, cfg_err);
    end
  endtask

  task automatic test_bad_order();
    cfg_write(4'd15, 16'h0000);
    pulse_commit();
    tests++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || flt_rst !== 1'b1) begin
      failed++;
      $display("FAIL bad_order0: err=%b busy=%b flt_rst=%b, required 1 0 1", cfg_err, busy, flt_rst);
    end
    cfg_write(4'd4, 16'($urandom));
    cfg_write(4'd15, 16'($urandom_range(9, 15)));
    pulse_commit();
    tests++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || coef_out !== exp_coef() || order_out !== m_order) begin
      failed++;
      $display("FAIL bad_order_high: err=%b busy=%b order=%h coef=%h, required 1 0 %h %h",
               cfg_err, busy, order_out, coef_out, m_order, exp_coef());
    end
    cfg_write(4'd15, 16'($urandom_range(1, 8)));
    pulse_commit();
    tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      failed++;
      $display("FAIL good_after_bad: err=%b busy=%b, required 0 1", cfg_err, busy);
    end
    wait_not_busy();
    tests++;
    if (coef_out !== exp_coef() || order_out !== m_order) begin
      failed++;
      $display("FAIL good_after_bad_set: order=%h coef=%h, required %h %h", order_out, coef_out, m_order, exp_coef());
    end
  endtask

  task automatic test_samples();
    logic v;
    logic [15:0] d;
    int n;
    x_valid = 1'b1; x_in = 16'h1234;
    @(negedge clk);
    x_valid = 1'b0;
    m_xout = 16'h1234;
    tests++;
    if (x_stb !== 1'b1 || x_out !== 16'h1234) begin
      failed++;
      $display("FAIL sample_1234: stb=%b x_out=%h, required 1 1234", x_stb, x_out);
    end
    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom);
      d = 16'($urandom);
      x_valid = v; x_in = d;
      @(negedge clk);
      if (v) m_xout = d;
      tests++;
      if (x_stb !== v || x_out !== m_xout) begin
        failed++;
        $display("FAIL sample_rand[%0d]: stb=%b x_out=%h, required %b %h", i, x_stb, x_out, v, m_xout);
      end
    end
    x_valid = 1'b0;
    // 10 samples across three flush windows (4 + 4 + 2)
    for (int k = 0; k < 3; k++) begin
      pulse_commit();
      n = (k == 2) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
        x_valid = 1'b1; x_in = 16'($urandom);
        @(negedge clk);
        m_drop++;
        tests++;
        if (x_stb !== 1'b0) begin
          failed++;
          $display("FAIL drop_stb[%0d.%0d]: stb=%b, required 0", k, i, x_stb);
        end
      end
      x_valid = 1'b0;
      wait_not_busy();
    end
    tests++;
    if (drop_cnt !== 16'(m_drop) || x_out !== m_xout || m_drop != 10) begin
      failed++;
      $display("FAIL drop_cnt: drop=%0d x_out=%h, required 10 %h", drop_cnt, x_out, m_xout);
    end
  endtask

  task automatic test_same_cycle();
    cfg_addr = 4'd2; cfg_data = 16'h0007; cfg_valid = 1'b1; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    m_shadow[2] = 16'h0007;
    model_commit();
    for (int i = 0; i < FLUSH; i++) begin
      tests++;
      if (busy !== 1'b1) begin
        failed++;
        $display("FAIL flush_len[%0d]: busy=%b, required 1", i, busy);
      end
      cfg_commit = (i == 1);
      @(negedge clk);
      cfg_commit = 1'b0;
    end
    tests++;
    if (busy !== 1'b0 || flt_rst !== 1'b1) begin
      failed++;
      $display("FAIL flush_ignore_commit: busy=%b flt_rst=%b, required 0 1", busy, flt_rst);
    end
    tests++;
    if (coef_out !== exp_coef() || coef_out[47:32] !== 16'h0007) begin
      failed++;
      $display("FAIL same_cycle_b2: got %h, required %h", coef_out, exp_coef());
    end
    // A write issued during a flush is held off, then lands in shadow only.
    pulse_commit();
    cfg_write(4'd3, 16'($urandom));
    tests++;
    if (coef_out !== exp_coef()) begin
      failed++;
      $display("FAIL held_write_shadow: got %h, required %h", coef_out, exp_coef());
    end
    pulse_commit();
    wait_not_busy();
    tests++;
    if (coef_out !== exp_coef()) begin
      failed++;
      $display("FAIL held_write_commit: got %h, required %h", coef_out, exp_coef());
    end
  endtask

  task automatic test_reset_flush();
    pulse_commit();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tests++;
    if (coef_out !== exp_coef() || order_out !== 4'd0 || flt_rst !== 1'b0 || busy !== 1'b0 ||
        drop_cnt !== 16'd0 || cfg_err !== 1'b0 || x_out !== 16'd0) begin
      failed++;
      $display("FAIL reset_flush: coef=%h order=%h flt_rst=%b busy=%b drop=%h err=%b x_out=%h, required all 0",
               coef_out, order_out, flt_rst, busy, drop_cnt, cfg_err, x_out);
    end
    @(negedge clk);
    tests++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || flt_rst !== 1'b0) begin
      failed++;
      $display("FAIL reset_flush_idle: ready=%b busy=%b flt_rst=%b, required 1 0 0", cfg_ready, busy, flt_rst);
    end
    pulse_commit();
    tests++;
    if (cfg_err !== 1'b1 || flt_rst !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL idle_bad_commit: err=%b flt_rst=%b busy=%b, required 1 0 0", cfg_err, flt_rst, busy);
    end
  endtask

`ifdef IIR_CFG_READBACK_EN
  task automatic test_readback();
    logic [3:0] a;
    rd_addr = 4'd0;
    @(negedge clk);
    tests++;
    if (rd_data !== 16'd0) begin
      failed++;
      $display("FAIL readback_reset: got %h, required 0000", rd_data);
    end
    cfg_write(4'd0, 16'h0005);
    for (int i = 0; i < 8; i++) cfg_write(4'($urandom), 16'($urandom));
    rd_addr = 4'd0;
    @(negedge clk);
    tests++;
    if (rd_data !== m_shadow[0]) begin
      failed++;
      $display("FAIL readback_b0: got %h, required %h", rd_data, m_shadow[0]);
    end
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom);
      rd_addr = a;
      @(negedge clk);
      tests++;
      if (rd_data !== m_shadow[a]) begin
        failed++;
        $display("FAIL readback[%0d]: got %h, required %h", a, rd_data, m_shadow[a]);
      end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_commit_basic();
    test_bad_order();
    test_samples();
    test_same_cycle();
    test_reset_flush();
`ifdef IIR_CFG_READBACK_EN
    test_readback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
